custom_bus_slave_regbank: RTL and testbench
===========================================

# custom_bus_slave_regbank

Parametrised slave for the custom request/ack bus. It replaces the single fixed 8-bit data register with an addressed register bank of DEPTH entries. It adds programmable wait states, an error response for out-of-range addresses, and a saturating error counter. It sits behind the bus master as a generic peripheral register endpoint, using the same request/ack/data-ack/done handshake.

## Interface
- DATA_W, 8, data width of bus and registers
- ADDR_W, 4, address width
- DEPTH, 16, number of registers (1..2**ADDR_W)
- WAIT_CYC, 0, wait-state cycles inserted after request acceptance (0..255)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m_req  in  1  master request, sampled in IDLE only
- m_r0_w1  in  1  direction: 0 read, 1 write; sampled with m_req
- m_addr  in  ADDR_W  register address; sampled with m_req
- m_wr_data  in  DATA_W  write data; sampled in WR_DATA
- m_done  in  1  master transaction-complete strobe
- m_rd_data  out  DATA_W  read data, valid only in RD_RESP, else 0
- s_ack  out  1  request acknowledge
- s_data_ack  out  1  write-data acknowledge
- s_err  out  1  error flag, asserted with s_ack / s_data_ack for an out-of-range address
- err_cnt  out  8  saturating count of errored transactions

## Operation
- The FSM is Moore. All bus outputs decode from the current state and latched flags only.
- States and transitions:
  - IDLE: on m_req, latch m_addr, m_r0_w1 and oor (m_addr >= DEPTH). Go to WAIT if WAIT_CYC>0, else to WR_ACK or RD_RESP according to direction.
  - WAIT: runs WAIT_CYC cycles on a down-counter, then goes to WR_ACK or RD_RESP.
  - WR_ACK → WR_DATA → WR_DATA_ACK → WR_DONE. Each of the first three lasts exactly 1 cycle.
  - WR_DONE: hold until m_done, then go to IDLE.
  - RD_RESP (1 cycle) → RD_DONE. RD_DONE: hold until m_done, then go to IDLE.
- Outputs per state:
  - WR_ACK and RD_RESP: s_ack=1.
  - WR_DATA_ACK: s_data_ack=1.
  - RD_RESP: m_rd_data = oor ? 0 : reg[addr].
  - s_err = oor in WR_ACK, WR_DATA_ACK and RD_RESP; 0 elsewhere.
- Write commit: at the clock edge leaving WR_DATA, reg[addr] <= m_wr_data, but only if !oor. An oor write is discarded and no register changes.
- err_cnt increments by 1 at the edge leaving WR_DATA_ACK or RD_RESP when oor=1, and saturates at 255.
- m_req outside IDLE is ignored; requests are not queued. m_done outside WR_DONE/RD_DONE is ignored. Any m_addr/m_r0_w1 change after acceptance has no effect.
- Any illegal state encoding returns to IDLE on the next edge.

## Timing
- Reset (async, immediate) sets:
  - state=IDLE, wait counter=0;
  - all registers=0, err_cnt=0;
  - m_rd_data=0, s_ack=0, s_data_ack=0, s_err=0.
- Reset mid-transaction aborts with no partial write. A write whose commit edge coincides with rst assertion is lost.
- Latency, with m_req high at edge E0 (accepted):
  - s_ack is high in cycle E0+1+WAIT_CYC.
  - Write: data is sampled at the end of cycle E0+2+WAIT_CYC; s_data_ack is high in cycle E0+3+WAIT_CYC.
  - Read: m_rd_data is valid in the same cycle as s_ack.
- m_done sampled high in a DONE state: IDLE is reached the next cycle. A new m_req is accepted at the earliest at the edge ending that IDLE cycle. There is no back-to-back acceptance from DONE.
- Read-after-write to the same address in the next transaction returns the new value.

## Structure
- Shared package custom_bus_pkg holds:
  - the state enum typedef (IDLE, WAIT, WR_ACK, WR_DATA, WR_DATA_ACK, WR_DONE, RD_RESP, RD_DONE);
  - the err_cnt width constant (8).
- Sub-module custom_bus_regfile(DATA_W, ADDR_W, DEPTH): synchronous write with enable, combinational read, async reset to 0.
- The top level contains the FSM, the wait counter, the address/direction/oor latches and err_cnt.

## Test plan
- Default params. Write 0xA5 to addr 3, then read addr 3. Required: s_ack at E0+1, s_data_ack at E0+3, read returns 0xA5 with s_ack; s_err=0 throughout.
- WAIT_CYC=3. Read addr 0 after reset. Required: s_ack at E0+4, m_rd_data=0x00; m_req pulses during WAIT are ignored.
- DEPTH=10. Write 0x3C to addr 12, then read addr 12. Required: s_err=1 with each ack, read data 0, no register changed, err_cnt=2.
- Hold m_done low for 5 cycles in WR_DONE. Required: the FSM stays in WR_DONE and all outputs are 0. On m_done=1 it returns to IDLE in 1 cycle.
- Assert rst during WR_DATA of a write of 0xFF to addr 1. Required: all outputs 0 immediately and addr 1 reads back 0x00.
- Issue 300 out-of-range reads. Required: err_cnt saturates at 255.

Source files
------------

// File: rtl/custom_bus_pkg.sv
// Shared types for the custom request/ack bus endpoints.
package custom_bus_pkg;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WR_ACK,
        WR_DATA,
        WR_DATA_ACK,
        WR_DONE,
        RD_RESP,
        RD_DONE
    } state_t;

endpackage

// File: rtl/custom_bus_regfile.sv
// Register bank: synchronous write with enable, combinational read, async clear.
// Addresses at or beyond DEPTH read as zero and ignore writes.
module custom_bus_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_i && (waddr_i == ADDR_W'(i))) mem_q[i] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_i == ADDR_W'(i)) rdata_o = mem_q[i];
        end
    end

endmodule

// File: rtl/custom_bus_slave_regbank.sv
// Addressed register endpoint for the request/ack bus: WAIT_CYC wait states, then ack
// (+data-ack for writes); holds in DONE until m_done. Out-of-range addresses flag s_err.
module custom_bus_slave_regbank
    import custom_bus_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_req,
    input  logic                 m_r0_w1,
    input  logic [ADDR_W-1:0]    m_addr,
    input  logic [DATA_W-1:0]    m_wr_data,
    input  logic                 m_done,
    output logic [DATA_W-1:0]    m_rd_data,
    output logic                 s_ack,
    output logic                 s_data_ack,
    output logic                 s_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t                state_q, state_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic                  oor_q, oor_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  s_ack_q, s_ack_d;
    logic                  s_data_ack_q, s_data_ack_d;
    logic                  s_err_q, s_err_d;
    logic                  reg_we;
    logic [DATA_W-1:0]     reg_rdata;

    custom_bus_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (reg_we),
        .waddr_i (addr_q),
        .wdata_i (m_wr_data),
        .raddr_i (addr_d),
        .rdata_o (reg_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        oor_d      = oor_q;
        err_cnt_d  = err_cnt_q;
        reg_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_req) begin
                    addr_d = m_addr;
                    wr_d   = m_r0_w1;
                    oor_d  = int'(m_addr) >= DEPTH;
                    if (WAIT_CYC > 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = 8'(WAIT_CYC - 1);
                    end else begin
                        state_d = m_r0_w1 ? WR_ACK : RD_RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 8'd0) state_d = wr_q ? WR_ACK : RD_RESP;
                else                    wait_cnt_d = wait_cnt_q - 8'd1;
            end
            WR_ACK:      state_d = WR_DATA;
            WR_DATA: begin
                state_d = WR_DATA_ACK;
                reg_we  = !oor_q;
            end
            WR_DATA_ACK: begin
                state_d = WR_DONE;
                if (oor_q && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            WR_DONE:     if (m_done) state_d = IDLE;
            RD_RESP: begin
                state_d = RD_DONE;
                if (oor_q && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            RD_DONE:     if (m_done) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so they track state_q exactly.
    always_comb begin
        s_ack_d      = (state_d == WR_ACK) || (state_d == RD_RESP);
        s_data_ack_d = (state_d == WR_DATA_ACK);
        s_err_d      = oor_d && (s_ack_d || s_data_ack_d);
        rd_data_d    = ((state_d == RD_RESP) && !oor_d) ? reg_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            oor_q        <= 1'b0;
            err_cnt_q    <= '0;
            rd_data_q    <= '0;
            s_ack_q      <= 1'b0;
            s_data_ack_q <= 1'b0;
            s_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            oor_q        <= oor_d;
            err_cnt_q    <= err_cnt_d;
            rd_data_q    <= rd_data_d;
            s_ack_q      <= s_ack_d;
            s_data_ack_q <= s_data_ack_d;
            s_err_q      <= s_err_d;
        end
    end

    assign m_rd_data  = rd_data_q;
    assign s_ack      = s_ack_q;
    assign s_data_ack = s_data_ack_q;
    assign s_err      = s_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_custom_bus_slave_regbank.sv
// Bench: two endpoints (DEPTH=16/WAIT_CYC=0 and DEPTH=10/WAIT_CYC=3) against a cycle-level transaction model.
module tb_custom_bus_slave_regbank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       m_req [2];
    logic       m_r0_w1 [2];
    logic       m_done [2];
    logic [3:0] m_addr [2];
    logic [7:0] m_wr_data [2];
    logic [7:0] m_rd_data [2];
    logic       s_ack [2];
    logic       s_data_ack [2];
    logic       s_err [2];
    logic [7:0] err_cnt [2];

    custom_bus_slave_regbank #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .m_req(m_req[0]), .m_r0_w1(m_r0_w1[0]), .m_addr(m_addr[0]),
        .m_wr_data(m_wr_data[0]), .m_done(m_done[0]), .m_rd_data(m_rd_data[0]),
        .s_ack(s_ack[0]), .s_data_ack(s_data_ack[0]), .s_err(s_err[0]), .err_cnt(err_cnt[0])
    );

    custom_bus_slave_regbank #(.DATA_W(8), .ADDR_W(4), .DEPTH(10), .WAIT_CYC(3)) u_dut1 (
        .clk(clk), .rst(rst), .m_req(m_req[1]), .m_r0_w1(m_r0_w1[1]), .m_addr(m_addr[1]),
        .m_wr_data(m_wr_data[1]), .m_done(m_done[1]), .m_rd_data(m_rd_data[1]),
        .s_ack(s_ack[1]), .s_data_ack(s_data_ack[1]), .s_err(s_err[1]), .err_cnt(err_cnt[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference state: register contents and error count per endpoint.
    logic [7:0] mem [2][16];
    int         errm [2];

    function automatic int waitc(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic int depth(input int d);
        return (d == 1) ? 10 : 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input int d, input string tag, input logic ack, input logic dack,
                            input logic err, input logic [7:0] rd);
        chk({tag, ".ack"}, 32'(s_ack[d]), 32'(ack));
        chk({tag, ".data_ack"}, 32'(s_data_ack[d]), 32'(dack));
        chk({tag, ".err"}, 32'(s_err[d]), 32'(err));
        chk({tag, ".rd_data"}, 32'(m_rd_data[d]), 32'(rd));
        chk({tag, ".err_cnt"}, 32'(err_cnt[d]), 32'(errm[d]));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            errm[d] = 0;
            for (int i = 0; i < 16; i++) mem[d][i] = 8'h00;
        end
    endtask

    // One full transaction, starting and ending at a negedge with the endpoint idle.
    task automatic txn(input int d, input bit wr, input logic [3:0] a, input logic [7:0] wd,
                       input int hold, output logic [7:0] rdv);
        int  w;
        int  n;
        bit  oor;
        logic exp_ack, exp_dack;
        w   = waitc(d);
        oor = (int'(a) >= depth(d));
        n   = wr ? w + 3 : w + 1;
        rdv = 8'h00;
        chk_outs(d, "idle", 1'b0, 1'b0, 1'b0, 8'h00);
        m_req[d] = 1'b1; m_r0_w1[d] = wr; m_addr[d] = a; m_wr_data[d] = 8'($urandom);
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            exp_ack  = (c == w + 1);
            exp_dack = wr && (c == w + 3);
            chk_outs(d, wr ? "wr" : "rd", exp_ack, exp_dack, oor && (exp_ack || exp_dack),
                     (!wr && exp_ack && !oor) ? mem[d][a] : 8'h00);
            if (exp_ack && !wr) rdv = m_rd_data[d];
            // Everything except the write data in WR_DATA must be ignored here.
            m_req[d] = 1'($urandom); m_r0_w1[d] = 1'($urandom);
            m_addr[d] = 4'($urandom); m_done[d] = 1'($urandom);
            m_wr_data[d] = (wr && c == w + 2) ? wd : 8'($urandom);
        end
        if (wr && !oor) mem[d][a] = wd;
        if (oor && errm[d] < 255) errm[d]++;
        m_done[d] = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk_outs(d, "done_hold", 1'b0, 1'b0, 1'b0, 8'h00);
            m_req[d] = 1'($urandom); m_addr[d] = 4'($urandom); m_done[d] = 1'b0;
        end
        @(negedge clk);
        chk_outs(d, "done", 1'b0, 1'b0, 1'b0, 8'h00);
        // A request coinciding with m_done must not be accepted.
        m_done[d] = 1'b1; m_req[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_done[d] = 1'b0; m_req[d] = 1'b0; m_r0_w1[d] = 1'b0; m_addr[d] = 4'h0;
        chk_outs(d, "back_idle", 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] rdv;
    int         d_r;
    logic [3:0] a_r;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_req[d] = 1'b0; m_r0_w1[d] = 1'b0; m_done[d] = 1'b0;
            m_addr[d] = 4'h0; m_wr_data[d] = 8'h00;
        end
        model_reset();
        rst = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) chk_outs(d, "reset", 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic write/read on the zero-wait endpoint.
        txn(0, 1'b1, 4'd3, 8'hA5, 0, rdv);
        txn(0, 1'b0, 4'd3, 8'h00, 0, rdv);
        chk("rd_after_wr", 32'(rdv), 32'h0000_00A5);

        // Wait states; m_req pulses during WAIT are scrambled inside txn.
        txn(1, 1'b0, 4'd0, 8'h00, 1, rdv);
        chk("wait_rd0", 32'(rdv), 32'h0);

        // Out-of-range write then read.
        txn(1, 1'b1, 4'd12, 8'h3C, 0, rdv);
        txn(1, 1'b0, 4'd12, 8'h00, 0, rdv);
        chk("oor_rd", 32'(rdv), 32'h0);
        chk("oor_err_cnt", 32'(err_cnt[1]), 32'd2);

        // Long hold in WR_DONE.
        txn(0, 1'b1, 4'd7, 8'h5A, 5, rdv);

        // Random traffic on both endpoints.
        for (int i = 0; i < 40; i++) begin
            d_r = int'($urandom_range(1, 0));
            a_r = 4'($urandom);
            txn(d_r, 1'($urandom), a_r, 8'($urandom), int'($urandom_range(3, 0)), rdv);
        end

        // Full readback: no stray writes anywhere.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) txn(d, 1'b0, 4'(i), 8'h00, 0, rdv);

        // Reset during WR_DATA of a write to addr 1.
        chk_outs(0, "pre_rst", 1'b0, 1'b0, 1'b0, 8'h00);
        m_req[0] = 1'b1; m_r0_w1[0] = 1'b1; m_addr[0] = 4'd1;
        @(posedge clk);
        @(negedge clk);
        m_req[0] = 1'b0;
        @(negedge clk);
        m_wr_data[0] = 8'hFF;
        #1 rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) chk_outs(d, "mid_rst", 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_r0_w1[0] = 1'b0; m_addr[0] = 4'd0; m_wr_data[0] = 8'h00;
        @(negedge clk);
        txn(0, 1'b0, 4'd1, 8'h00, 0, rdv);
        chk("rst_lost_write", 32'(rdv), 32'h0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) txn(1, 1'b0, 4'($urandom_range(15, 10)), 8'h00, 0, rdv);
        chk("err_cnt_sat", 32'(err_cnt[1]), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
